// File: rtl/alu_op_sequencer_if.sv
// Command / ALU / response bundle for alu_op_sequencer.
// slave  : the sequencer's view (takes commands, drives the ALU, returns results).
// master : the surrounding environment (issues commands, models the ALU, takes results).
interface alu_op_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 5
);
  // command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic              cmd_mode;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [CNT_W-1:0]  cmd_count;
  // ALU drive / return
  logic [DATA_W-1:0] alu_in_1;
  logic [DATA_W-1:0] alu_in_2;
  logic              alu_mode;
  logic [OP_W-1:0]   alu_operation;
  logic [DATA_W-1:0] alu_result;
  logic              alu_overflow;
  // response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_overflow;
  logic [CNT_W:0]    rsp_passes;

  modport slave (
    input  cmd_valid, cmd_op, cmd_mode, cmd_a, cmd_b, cmd_count,
    output cmd_ready,
    output alu_in_1, alu_in_2, alu_mode, alu_operation,
    input  alu_result, alu_overflow,
    output rsp_valid, rsp_result, rsp_overflow, rsp_passes,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_mode, cmd_a, cmd_b, cmd_count,
    input  cmd_ready,
    input  alu_in_1, alu_in_2, alu_mode, alu_operation,
    output alu_result, alu_overflow,
    input  rsp_valid, rsp_result, rsp_overflow, rsp_passes,
    output rsp_ready
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue stage for the combinational 32-bit ALU.
// Accepts one command, runs it as one ALU pass (or N single-bit passes for
// shifts), accumulating the ALU result, then presents result / sticky
// overflow / pass count on the response port.
// Optional: define ALU_SEQ_SIGN_FILL_EN to force the MSB of every sra pass to
// the sign of the original operand (true arithmetic shift independent of ALU).
module alu_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   bus,
  output logic                busy
);

  localparam logic [OP_W-1:0] OP_SLL = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SRL = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SRA = OP_W'(4);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] acc, acc_nxt, b_reg;
  logic [OP_W-1:0]   op_reg;
  logic              mode_reg;
  logic              ovf;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W:0]    passes;
  logic              accept, is_shift;

  assign accept   = bus.cmd_valid && bus.cmd_ready;
  assign is_shift = (bus.cmd_op == OP_SLL) || (bus.cmd_op == OP_SRL) ||
                    (bus.cmd_op == OP_SRA);

`ifdef ALU_SEQ_SIGN_FILL_EN
  logic sign_reg;

  // remember the sign of the original operand for sra sign fill
  always_ff @(posedge clk) begin
    if (rst)         sign_reg <= 1'b0;
    else if (accept) sign_reg <= bus.cmd_a[DATA_W-1];
  end

  // sra passes keep the original sign in the MSB
  always_comb begin
    acc_nxt = bus.alu_result;
    if (op_reg == OP_SRA) acc_nxt[DATA_W-1] = sign_reg;
  end
`else
  assign acc_nxt = bus.alu_result;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state: zero-count shifts skip EXEC; last pass is remaining==1
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)
              state_nxt = (is_shift && bus.cmd_count == '0) ? DONE : EXEC;
      EXEC: if (remaining == CNT_W'(1)) state_nxt = DONE;
      DONE: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // operand latch on accept, accumulate ALU result on every EXEC cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      mode_reg  <= 1'b0;
      ovf       <= 1'b0;
      remaining <= '0;
      passes    <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          acc       <= bus.cmd_a;
          b_reg     <= bus.cmd_b;
          op_reg    <= bus.cmd_op;
          mode_reg  <= bus.cmd_mode;
          ovf       <= 1'b0;
          passes    <= '0;
          remaining <= is_shift ? bus.cmd_count : CNT_W'(1);
        end
        EXEC: begin
          acc       <= acc_nxt;
          ovf       <= ovf | bus.alu_overflow;
          passes    <= passes + (CNT_W+1)'(1);
          remaining <= remaining - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // ALU is driven straight from registers so its inputs never glitch
  assign bus.alu_in_1      = acc;
  assign bus.alu_in_2      = b_reg;
  assign bus.alu_operation = op_reg;
  assign bus.alu_mode      = mode_reg;

  // response fields are the registered accumulator state, frozen in DONE
  assign bus.cmd_ready     = (state == IDLE) && !rst;
  assign bus.rsp_valid     = (state == DONE);
  assign bus.rsp_result    = acc;
  assign bus.rsp_overflow  = ovf;
  assign bus.rsp_passes    = passes;
  assign busy              = (state != IDLE);

endmodule
